// File: rtl/mips32_prog_loader_pkg.sv
// mips32_prog_loader_pkg: pipe_MIPS32 opcode/type constants and loader state encoding
package mips32_prog_loader_pkg;
  localparam int MEM_DEPTH_DEFAULT = 1024;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND = 6'b000010, OR = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, HLT = 6'b111111, LW = 6'b001000;
  localparam logic [5:0] SW = 6'b001001, ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;
  localparam logic [2:0] RR_ALU = 3'b000, RM_ALU = 3'b001, LOAD = 3'b010;
  localparam logic [2:0] STORE = 3'b011, BRANCH = 3'b100, HALT = 3'b101;
  typedef enum logic [2:0] {LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_CHK, LD_DONE, LD_ERR} ld_state_t;
endpackage

// File: rtl/mips32_prog_loader_if.sv
// mips32_prog_loader_if: byte stream in, memory write port and load status out
interface mips32_prog_loader_if #(parameter int AW = 10);
  logic in_valid, in_ready, restart, mem_we, cpu_hold, load_done, load_err;
  logic [7:0] in_data;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_loaded;
  modport master (output in_valid, in_data, restart,
                  input in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_loaded);
  modport slave (input in_valid, in_data, restart,
                 output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_loaded);
endinterface

// File: rtl/mips32_word_packer.sv
// mips32_word_packer: shifts in big-endian bytes, pulses word_valid the cycle after the 4th byte
module mips32_word_packer (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt
);
  // shift register and byte counter; word stays stable during the word_valid cycle
  always_ff @(posedge clk1)
    if (!rst_n || clr) begin
      byte_cnt <= 2'd0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && byte_cnt == 2'd3;
      if (byte_en) begin
        word <= {word[23:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
endmodule

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: streams a length-prefixed image into core memory; LOADER_CHECKSUM_EN adds a trailing XOR byte
module mips32_prog_loader
  import mips32_prog_loader_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int BASE_ADDR = 0
) (
  input logic clk1,
  input logic rst_n,
  mips32_prog_loader_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t AFTER_DATA = LD_CHK;
  logic [7:0] csum;
`else
  localparam ld_state_t AFTER_DATA = LD_DONE;
`endif
  ld_state_t state, state_nx;
  logic up, xfer, fourth, last_word, word_valid, done_q, err_q, hold_q;
  logic [31:0] word;
  logic [1:0] byte_cnt;
  logic [7:0] len_hi;
  logic [15:0] len_in, n, cnt;
  logic [AW-1:0] waddr;
  assign len_in = {len_hi, bus.in_data};
  assign xfer = bus.in_valid && bus.in_ready && !bus.restart;
  assign fourth = xfer && state == LD_DATA && byte_cnt == 2'd3;
  assign last_word = fourth && cnt + 16'd1 == n;
  mips32_word_packer packer (
    .clk1(clk1), .rst_n(rst_n), .clr(bus.restart), .byte_en(xfer && state == LD_DATA),
    .byte_in(bus.in_data), .word_valid(word_valid), .word(word), .byte_cnt(byte_cnt)
  );
  // state register; up keeps in_ready low through the reset cycle
  always_ff @(posedge clk1)
    if (!rst_n) begin
      state <= LD_LEN_HI;
      up <= 1'b0;
    end else begin
      state <= state_nx;
      up <= 1'b1;
    end
  // next state: restart overrides any byte accepted in the same cycle
  always_comb begin
    state_nx = state;
    if (bus.restart) state_nx = LD_LEN_HI;
    else if (xfer)
      case (state)
        LD_LEN_HI: state_nx = LD_LEN_LO;
        LD_LEN_LO: state_nx = 32'(len_in) > MEM_DEPTH - BASE_ADDR ? LD_ERR : len_in == 16'd0 ? AFTER_DATA : LD_DATA;
        LD_DATA:   state_nx = last_word ? AFTER_DATA : LD_DATA;
`ifdef LOADER_CHECKSUM_EN
        LD_CHK:    state_nx = bus.in_data == csum ? LD_DONE : LD_ERR;
`endif
        default:   state_nx = state;
      endcase
  end
  // stream is accepted in every state except the two terminal ones
  always_comb begin
    bus.in_ready = up && state != LD_DONE && state != LD_ERR;
  end
  // length, word count, write address and running checksum
  always_ff @(posedge clk1)
    if (!rst_n || bus.restart) begin
      len_hi <= 8'd0;
      n <= 16'd0;
      cnt <= 16'd0;
      waddr <= AW'(BASE_ADDR);
`ifdef LOADER_CHECKSUM_EN
      csum <= 8'd0;
`endif
    end else begin
      if (xfer && state == LD_LEN_HI) len_hi <= bus.in_data;
      if (xfer && state == LD_LEN_LO) n <= len_in;
      if (fourth) cnt <= cnt + 16'd1;
      if (word_valid) waddr <= waddr + AW'(1);
`ifdef LOADER_CHECKSUM_EN
      if (xfer && state == LD_DATA) csum <= csum ^ bus.in_data;
`endif
    end
  // status flags follow the state one cycle later
  always_ff @(posedge clk1)
    if (!rst_n || bus.restart) begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      hold_q <= 1'b1;
    end else begin
      done_q <= state == LD_DONE;
      err_q <= state == LD_ERR;
      hold_q <= state != LD_DONE;
    end
  assign bus.mem_we = word_valid;
  assign bus.mem_addr = waddr;
  assign bus.mem_wdata = word;
  assign bus.cpu_hold = hold_q;
  assign bus.load_done = done_q;
  assign bus.load_err = err_q;
  assign bus.words_loaded = cnt;
endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb_mips32_prog_loader: scoreboard bench for the program loader
module tb_mips32_prog_loader;
  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  mips32_prog_loader_if #(.AW(10)) bus();
  mips32_prog_loader dut (.clk1(clk1), .rst_n(rst_n), .bus(bus));
  always #5 clk1 = ~clk1;

  typedef struct packed {logic [9:0] addr; logic [31:0] data;} wr_t;
  wr_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  logic [9:0] next_addr = 10'd0;
  logic [7:0] csum = 8'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // every write strobe must match the oldest expected write
  always @(negedge clk1) begin : mon
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_we", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("waddr", 32'(bus.mem_addr), 32'(e.addr));
        check("wdata", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk1);
      ok = bus.in_ready;
      @(posedge clk1);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_q.push_back({next_addr, w});
    next_addr++;
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8+:8]);
      csum ^= w[i*8+:8];
    end
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    next_addr = 10'd0;
    csum = 8'd0;
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic done, input logic err,
                              input logic hold, input logic [15:0] words);
    @(negedge clk1);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'(rdy));
    check({tag, "_done"}, 32'(bus.load_done), 32'(done));
    check({tag, "_err"}, 32'(bus.load_err), 32'(err));
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(hold));
    check({tag, "_words"}, 32'(bus.words_loaded), 32'(words));
    @(posedge clk1);
    #1;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk1);
    check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
  endtask

  initial begin
    logic [31:0] w;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    bus.restart = 1'b0;
    tick(3);
    check_reset("rst");
    rst_n = 1'b1;
    tick();
    check_status("post_rst", 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);

    send_len(16'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
    check("t1_csum", 32'(csum), 32'h2A);
    send_byte(csum);
`endif
    tick(2);
    check_status("t1", 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    check("t1_q", exp_q.size(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    pulse_restart();
    check_status("t2_rst", 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
    send_len(16'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    send_byte(8'h00);
    tick(2);
    check_status("t2", 1'b0, 1'b0, 1'b1, 1'b1, 16'd2);
`endif

    pulse_restart();
    send_len(16'd1025);
    tick();
    check_status("t3", 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    pulse_restart();
    send_len(16'd1024);
    tick();
    check_status("t3_max", 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);

    pulse_restart();
    send_len(16'd1);
    w = 32'hA1B2C3D4;
    exp_q.push_back({next_addr, w});
    next_addr++;
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8+:8]);
      csum ^= w[i*8+:8];
      if (i > 0) tick();
    end
    @(negedge clk1);
    check("t4_we", 32'(bus.mem_we), 32'd1);
    check("t4_words", 32'(bus.words_loaded), 32'd1);
    @(posedge clk1);
    #1;
    @(negedge clk1);
    check("t4_we_off", 32'(bus.mem_we), 32'd0);
    @(posedge clk1);
    #1;
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    tick(2);
    check_status("t4", 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);

    pulse_restart();
    send_len(16'd2);
    send_word(32'h0BADF00D);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.restart = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h99;
    tick();
    bus.restart = 1'b0;
    bus.in_valid = 1'b0;
    next_addr = 10'd0;
    csum = 8'd0;
    check_status("t5_rst", 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
    send_len(16'd1);
    send_word(32'hCAFEBABE);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    tick(2);
    check_status("t5", 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);

    pulse_restart();
    send_len(16'd0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    tick(2);
    check_status("t6", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    pulse_restart();
    send_len(16'd1);
    send_byte(8'h55);
    send_byte(8'h66);
    rst_n = 1'b0;
    tick();
    next_addr = 10'd0;
    csum = 8'd0;
    check_reset("t6_rst");
    rst_n = 1'b1;
    tick();
    check_status("t6_rel", 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
    send_len(16'd1);
    send_word(32'h01020304);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    tick(2);
    check_status("t6_after", 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    check("final_q", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
